// File: rtl/vga_mon_pkg.sv
// Shared constants for the VGA frame monitor: timing defaults,
// FSM state codes, register addresses and a saturating increment.
package vga_mon_pkg;

    localparam int H_TOTAL_DEF   = 800;
    localparam int H_ACTIVE_DEF  = 640;
    localparam int V_TOTAL_DEF   = 525;
    localparam int V_ACTIVE_DEF  = 480;
    localparam int TIMEOUT_LINES = 1023;

    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    localparam logic [2:0] REG_STATUS = 3'd0;
    localparam logic [2:0] REG_FRAMES = 3'd1;
    localparam logic [2:0] REG_ERRORS = 3'd2;
    localparam logic [2:0] REG_CSUM   = 3'd3;
    localparam logic [2:0] REG_FG     = 3'd4;
    localparam logic [2:0] REG_HTIME  = 3'd5;
    localparam logic [2:0] REG_VTIME  = 3'd6;
    localparam logic [2:0] REG_BG     = 3'd7;

    localparam logic [23:0] BG_RESET = 24'h500000;

    function automatic logic [11:0] sat_inc(input logic [11:0] v,
                                            input logic        en);
        return (en && v != 12'hFFF) ? v + 12'd1 : v;
    endfunction

endpackage

// File: rtl/vga_mon_sampler.sv
// Registers the VGA inputs once and derives pixel ticks and
// sync falling edges as seen from one tick to the next.
module vga_mon_sampler (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  vga_r,
    input  logic [7:0]  vga_g,
    input  logic [7:0]  vga_b,
    input  logic        vga_clk,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic        vga_blank_n,
    output logic        tick,
    output logic        hs_fall,
    output logic        vs_fall,
    output logic [23:0] pix_rgb,
    output logic        pix_blank_n
);

    logic [23:0] rgb_q, rgb_d;
    logic        clk_q, clk_d;
    logic        clk_prev_q, clk_prev_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        blank_q, blank_d;
    logic        hs_last_q, hs_last_d;
    logic        vs_last_q, vs_last_d;

    assign tick        = clk_q & ~clk_prev_q;
    assign hs_fall     = tick & hs_last_q & ~hs_q;
    assign vs_fall     = tick & vs_last_q & ~vs_q;
    assign pix_rgb     = rgb_q;
    assign pix_blank_n = blank_q;

    always_comb begin
        rgb_d      = {vga_r, vga_g, vga_b};
        clk_d      = vga_clk;
        clk_prev_d = clk_q;
        hs_d       = vga_hs;
        vs_d       = vga_vs;
        blank_d    = vga_blank_n;
        // sync levels remembered per tick, so edges are tick-to-tick
        hs_last_d  = tick ? hs_q : hs_last_q;
        vs_last_d  = tick ? vs_q : vs_last_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_q      <= '0;
            clk_q      <= 1'b0;
            clk_prev_q <= 1'b0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            blank_q    <= 1'b0;
            hs_last_q  <= 1'b0;
            vs_last_q  <= 1'b0;
        end else begin
            rgb_q      <= rgb_d;
            clk_q      <= clk_d;
            clk_prev_q <= clk_prev_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            blank_q    <= blank_d;
            hs_last_q  <= hs_last_d;
            vs_last_q  <= vs_last_d;
        end
    end

endmodule

// File: rtl/vga_frame_monitor.sv
// Measures VGA frame timing and pixel statistics, tracks lock
// state and exposes results over an Avalon-MM register slave.
module vga_frame_monitor
    import vga_mon_pkg::*;
#(
    parameter int H_TOTAL  = H_TOTAL_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_TOTAL  = V_TOTAL_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  VGA_R,
    input  logic [7:0]  VGA_G,
    input  logic [7:0]  VGA_B,
    input  logic        VGA_CLK,
    input  logic        VGA_HS,
    input  logic        VGA_VS,
    input  logic        VGA_BLANK_n,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [2:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata
);

    localparam logic [11:0] HT_L = 12'(H_TOTAL);
    localparam logic [11:0] HA_L = 12'(H_ACTIVE);
    localparam logic [11:0] VT_L = 12'(V_TOTAL);
    localparam logic [11:0] VA_L = 12'(V_ACTIVE);
    localparam logic [11:0] TO_L = 12'(TIMEOUT_LINES);

    logic        tick, hs_fall, vs_fall, pix_blank_n;
    logic [23:0] pix_rgb;

    vga_mon_sampler u_sampler (
        .clk         (clk),
        .reset_n     (reset_n),
        .vga_r       (VGA_R),
        .vga_g       (VGA_G),
        .vga_b       (VGA_B),
        .vga_clk     (VGA_CLK),
        .vga_hs      (VGA_HS),
        .vga_vs      (VGA_VS),
        .vga_blank_n (VGA_BLANK_n),
        .tick        (tick),
        .hs_fall     (hs_fall),
        .vs_fall     (vs_fall),
        .pix_rgb     (pix_rgb),
        .pix_blank_n (pix_blank_n)
    );

    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] h_last_q, h_last_d;
    logic [11:0] line_act_q, line_act_d;
    logic [11:0] h_max_q, h_max_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic [11:0] v_act_q, v_act_d;
    logic [31:0] csum_q, csum_d;
    logic [19:0] fg_q, fg_d;
    logic        armed_q, armed_d;
    logic [1:0]  state_q, state_d;
    logic [15:0] frames_q, frames_d;
    logic [15:0] errors_q, errors_d;
    logic [31:0] s_csum_q, s_csum_d;
    logic [19:0] s_fg_q, s_fg_d;
    logic [11:0] s_htot_q, s_htot_d;
    logic [11:0] s_hact_q, s_hact_d;
    logic [11:0] s_vtot_q, s_vtot_d;
    logic [11:0] s_vact_q, s_vact_d;
    logic [23:0] bg_q, bg_d;
    logic [31:0] rdata_q, rdata_d;

    logic        new_line, match, timeout, wr, rd, fg_hit;
    logic [11:0] line_len, la_base, la_next, hmax_base;
    logic [9:0]  pix_sum;
    logic [7:0]  unused_wd;

    assign unused_wd = writedata[31:24];
    assign readdata  = rdata_q;

    always_comb begin
        h_cnt_d    = h_cnt_q;
        h_last_d   = h_last_q;
        line_act_d = line_act_q;
        h_max_d    = h_max_q;
        v_cnt_d    = v_cnt_q;
        v_act_d    = v_act_q;
        csum_d     = csum_q;
        fg_d       = fg_q;
        armed_d    = armed_q;
        state_d    = state_q;
        frames_d   = frames_q;
        errors_d   = errors_q;
        s_csum_d   = s_csum_q;
        s_fg_d     = s_fg_q;
        s_htot_d   = s_htot_q;
        s_hact_d   = s_hact_q;
        s_vtot_d   = s_vtot_q;
        s_vact_d   = s_vact_q;
        bg_d       = bg_q;
        rdata_d    = rdata_q;

        wr       = chipselect & write;
        rd       = chipselect & read;
        new_line = hs_fall | vs_fall;
        // the line that ends on this tick still belongs to the old frame
        line_len  = hs_fall ? h_cnt_q : h_last_q;
        la_base   = new_line ? 12'd0 : line_act_q;
        la_next   = sat_inc(la_base, pix_blank_n);
        hmax_base = vs_fall ? 12'd0 : h_max_q;
        pix_sum   = {2'b0, pix_rgb[23:16]} + {2'b0, pix_rgb[15:8]}
                  + {2'b0, pix_rgb[7:0]};
        fg_hit    = pix_blank_n && (pix_rgb != bg_q);
        match     = (line_len == HT_L) && (h_max_q == HA_L)
                  && (v_cnt_q == VT_L) && (v_act_q == VA_L);
        timeout   = tick & armed_q & hs_fall & ~vs_fall
                  & (v_cnt_q >= TO_L);

        if (tick && (armed_q || vs_fall)) begin
            h_cnt_d    = sat_inc(new_line ? 12'd0 : h_cnt_q, 1'b1);
            h_last_d   = vs_fall ? 12'd0 : line_len;
            line_act_d = la_next;
            h_max_d    = (la_next > hmax_base) ? la_next : hmax_base;
            v_cnt_d    = sat_inc(vs_fall ? 12'd0 : v_cnt_q, hs_fall);
            v_act_d    = sat_inc(vs_fall ? 12'd0 : v_act_q,
                                 pix_blank_n && (la_base == 12'd0));
            csum_d     = (vs_fall ? 32'd0 : csum_q)
                       + (pix_blank_n ? {22'd0, pix_sum} : 32'd0);
            fg_d       = (vs_fall ? 20'd0 : fg_q) + {19'd0, fg_hit};
        end

        if (vs_fall) begin
            armed_d  = 1'b1;
            s_csum_d = csum_q;
            s_fg_d   = fg_q;
            s_htot_d = line_len;
            s_hact_d = h_max_q;
            s_vtot_d = v_cnt_q;
            s_vact_d = v_act_q;
            case (state_q)
                ST_SEARCH: state_d = ST_MEASURE;
                ST_MEASURE: begin
                    state_d = match ? ST_LOCKED : ST_SEARCH;
                    if (!match) errors_d = errors_q + 16'd1;
                end
                ST_LOCKED: begin
                    if (match) begin
                        frames_d = frames_q + 16'd1;
                    end else begin
                        state_d  = ST_SEARCH;
                        errors_d = errors_q + 16'd1;
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end else if (timeout) begin
            // disarm so a stuck VS is reported only once
            armed_d  = 1'b0;
            state_d  = ST_SEARCH;
            errors_d = errors_q + 16'd1;
        end

        if (wr && address == REG_STATUS && writedata[0]) begin
            frames_d = '0;
            errors_d = '0;
        end
        if (wr && address == REG_BG) bg_d = writedata[23:0];

        if (rd) begin
            case (address)
                REG_STATUS: rdata_d = {29'd0, state_q == ST_LOCKED, state_q};
                REG_FRAMES: rdata_d = {16'd0, frames_q};
                REG_ERRORS: rdata_d = {16'd0, errors_q};
                REG_CSUM:   rdata_d = s_csum_q;
                REG_FG:     rdata_d = {12'd0, s_fg_q};
                REG_HTIME:  rdata_d = {4'd0, s_htot_q, 4'd0, s_hact_q};
                REG_VTIME:  rdata_d = {4'd0, s_vtot_q, 4'd0, s_vact_q};
                REG_BG:     rdata_d = {8'd0, bg_q};
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_q    <= '0;
            h_last_q   <= '0;
            line_act_q <= '0;
            h_max_q    <= '0;
            v_cnt_q    <= '0;
            v_act_q    <= '0;
            csum_q     <= '0;
            fg_q       <= '0;
            armed_q    <= 1'b0;
            state_q    <= ST_SEARCH;
            frames_q   <= '0;
            errors_q   <= '0;
            s_csum_q   <= '0;
            s_fg_q     <= '0;
            s_htot_q   <= '0;
            s_hact_q   <= '0;
            s_vtot_q   <= '0;
            s_vact_q   <= '0;
            bg_q       <= BG_RESET;
            rdata_q    <= '0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            h_last_q   <= h_last_d;
            line_act_q <= line_act_d;
            h_max_q    <= h_max_d;
            v_cnt_q    <= v_cnt_d;
            v_act_q    <= v_act_d;
            csum_q     <= csum_d;
            fg_q       <= fg_d;
            armed_q    <= armed_d;
            state_q    <= state_d;
            frames_q   <= frames_d;
            errors_q   <= errors_d;
            s_csum_q   <= s_csum_d;
            s_fg_q     <= s_fg_d;
            s_htot_q   <= s_htot_d;
            s_hact_q   <= s_hact_d;
            s_vtot_q   <= s_vtot_d;
            s_vact_q   <= s_vact_d;
            bg_q       <= bg_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule
